sc_hit_scheduler: RTL and testbench

- Collects timing-delta hit events from NUM_LANES fret lanes and serialises them onto the single shared score unit (dt/en/score datapath).
- Round-robin arbitration; one-deep holding register per lane.
- Enforces a minimum spacing of ISSUE_GAP idle cycles between score-unit enables.
- Sits between the per-lane note judges and the score accumulator.

---
 rtl/sc_hit_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_sc_hit_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_hit_scheduler.sv
// sc_hit_scheduler
//   Collects timing-delta hits from NUM_LANES fret lanes and serialises them
//   onto the single shared score unit. Each lane has a one-deep holding
//   register. Arbitration is round-robin. After every score-unit enable,
//   ISSUE_GAP idle cycles are forced before the next one.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   hit_valid  in   [NUM_LANES]       per-lane one-cycle hit strobe
//   hit_dt     in   [NUM_LANES*DT_W]  packed dt, lane i at [i*DT_W +: DT_W]
//   hit_drop   out  [NUM_LANES]       hit rejected because the holder was full
//   sc_dt      out  [DT_W]            dt presented to the score unit
//   sc_en      out                    one-cycle score-unit enable
//   sc_lane    out  [3]               lane index of the current/last issue
//   pending    out  [NUM_LANES]       holder-occupied flags
//   streak     out  [8]               consecutive good-hit count
//
// Optional feature macro: SC_STREAK_EN
//   Defined   : streak counts consecutive issues with dt <= HIT_WIN
//               (saturating at 255). It updates the cycle after sc_en.
//   Undefined : streak is tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | may grant the next pending lane on this edge
// ST_GAP  | post-issue spacing; gap_cnt_q counts down, exit at 1

module sc_hit_scheduler #(
    parameter int NUM_LANES = 5,
    parameter int DT_W      = 16,
    parameter int ISSUE_GAP = 2,
    parameter int HIT_WIN   = 50
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_LANES-1:0]      hit_valid,
    input  logic [NUM_LANES*DT_W-1:0] hit_dt,
    output logic [NUM_LANES-1:0]      hit_drop,
    output logic [DT_W-1:0]           sc_dt,
    output logic                      sc_en,
    output logic [2:0]                sc_lane,
    output logic [NUM_LANES-1:0]      pending,
    output logic [7:0]                streak
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic [2:0]             rr_q;
    logic [NUM_LANES-1:0]   pend_q, pend_d;
    logic [NUM_LANES-1:0]   drop_q, drop_d;
    logic [NUM_LANES-1:0]   load;
    logic [DT_W-1:0]        hold_q [NUM_LANES];
    logic [DT_W-1:0]        sc_dt_q;
    logic [2:0]             sc_lane_q;
    logic                   sc_en_q;

    logic                   grant_vld;
    logic [2:0]             grant_idx;
    logic [NUM_LANES-1:0]   grant_oh;
    logic [3:0]             cand;

    // Round-robin search starting one past the last granted lane.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = 4'(rr_q) + 4'(k);
            if (cand >= 4'(NUM_LANES)) begin
                cand = cand - 4'(NUM_LANES);
            end
            if (!grant_vld && pend_q[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = 3'(cand);
            end
        end
        if (state_q != ST_IDLE) begin
            grant_vld = 1'b0;
        end
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx[IDX_W-1:0]] = 1'b1;
        end
    end

    // A granted lane frees its holder on the same edge, so a strobe that
    // coincides with the grant reloads instead of dropping.
    always_comb begin
        load   = hit_valid & (~pend_q | grant_oh);
        drop_d = hit_valid & pend_q & ~grant_oh;
        pend_d = (pend_q & ~grant_oh) | hit_valid;
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld && (ISSUE_GAP > 0)) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = 4'(ISSUE_GAP);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            rr_q      <= 3'(NUM_LANES - 1);
            pend_q    <= '0;
            drop_q    <= '0;
            sc_dt_q   <= '0;
            sc_lane_q <= '0;
            sc_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            sc_en_q   <= grant_vld;
            if (grant_vld) begin
                rr_q      <= grant_idx;
                sc_lane_q <= grant_idx;
                sc_dt_q   <= hold_q[grant_idx[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (load[i]) begin
                    hold_q[i] <= hit_dt[i*DT_W +: DT_W];
                end
            end
        end
    end

`ifdef SC_STREAK_EN
    logic [7:0] streak_q;

    // Judged from the registered issue, hence one cycle behind sc_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (sc_en_q) begin
            if (sc_dt_q <= DT_W'(HIT_WIN)) begin
                if (streak_q != 8'hFF) begin
                    streak_q <= streak_q + 8'd1;
                end
            end else begin
                streak_q <= '0;
            end
        end
    end

    assign streak = streak_q;
`else
    assign streak = 8'h00;
`endif

    assign hit_drop = drop_q;
    assign sc_dt    = sc_dt_q;
    assign sc_en    = sc_en_q;
    assign sc_lane  = sc_lane_q;
    assign pending  = pend_q;

endmodule

// File: tb/tb_sc_hit_scheduler.sv
module tb_sc_hit_scheduler;

    localparam int N   = 5;
    localparam int DW  = 16;
    localparam int GAP = 2;
    localparam int HW  = 50;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      hit_valid;
    logic [N*DW-1:0]   hit_dt;
    logic [N-1:0]      hit_drop;
    logic [DW-1:0]     sc_dt;
    logic              sc_en;
    logic [2:0]        sc_lane;
    logic [N-1:0]      pending;
    logic [7:0]        streak;

    sc_hit_scheduler #(
        .NUM_LANES (N),
        .DT_W      (DW),
        .ISSUE_GAP (GAP),
        .HIT_WIN   (HW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit_valid (hit_valid),
        .hit_dt    (hit_dt),
        .hit_drop  (hit_drop),
        .sc_dt     (sc_dt),
        .sc_en     (sc_en),
        .sc_lane   (sc_lane),
        .pending   (pending),
        .streak    (streak)
    );

    always #5 clk = ~clk;

    int vectors  = 0;
    int errors   = 0;
    int cycle_no = 0;

    // Reference model: per-lane holders, last-granted pointer, and a
    // cooldown count of edges that must pass before the next grant.
    logic [N-1:0]  m_pend;
    logic [DW-1:0] m_hold [N];
    int            m_rr;
    int            m_cool;
    logic          m_en;
    logic [DW-1:0] m_dt;
    int            m_lane;
    logic [N-1:0]  m_drop;
    int            m_streak;

    int log_lane [$];
    int log_dt   [$];
    int log_cyc  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    task automatic model_reset();
        m_pend   = '0;
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        m_rr     = N - 1;
        m_cool   = 0;
        m_en     = 1'b0;
        m_dt     = '0;
        m_lane   = 0;
        m_drop   = '0;
        m_streak = 0;
        log_lane.delete();
        log_dt.delete();
        log_cyc.delete();
    endtask

    task automatic model_step();
        bit gv;
        int g;
`ifdef SC_STREAK_EN
        if (m_en) begin
            if (int'(m_dt) <= HW) m_streak = (m_streak >= 255) ? 255 : m_streak + 1;
            else                  m_streak = 0;
        end
`endif
        gv = 1'b0;
        g  = 0;
        if (m_cool == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (!gv && m_pend[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end else begin
            m_cool--;
        end
        m_en   = gv;
        m_drop = '0;
        if (gv) begin
            m_dt      = m_hold[g];
            m_lane    = g;
            m_rr      = g;
            m_cool    = GAP;
            m_pend[g] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (hit_valid[i]) begin
                if (!m_pend[i]) begin
                    m_hold[i] = hit_dt[i*DW +: DW];
                    m_pend[i] = 1'b1;
                end else begin
                    m_drop[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("sc_en",    32'(sc_en),    32'(m_en));
        chk("sc_dt",    32'(sc_dt),    32'(m_dt));
        chk("sc_lane",  32'(sc_lane),  32'(m_lane));
        chk("pending",  32'(pending),  32'(m_pend));
        chk("hit_drop", 32'(hit_drop), 32'(m_drop));
        chk("streak",   32'(streak),   32'(m_streak));
        if (sc_en) begin
            log_lane.push_back(int'(sc_lane));
            log_dt.push_back(int'(sc_dt));
            log_cyc.push_back(cycle_no);
        end
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d);
        @(negedge clk);
        hit_valid = v;
        hit_dt    = d;
        @(posedge clk);
        model_step();
        #1;
        compare();
        cycle_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        hit_valid = '0;
        hit_dt    = '0;
        rst_n     = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N*DW-1:0] put(input logic [N*DW-1:0] base, input int lane, input int val);
        logic [N*DW-1:0] r;
        r = base;
        r[lane*DW +: DW] = DW'(val);
        return r;
    endfunction

    task automatic chk_log(input string name, input int idx, input int lane, input int dt);
        if (log_lane.size() > idx) begin
            chk({name, "_lane"}, 32'(log_lane[idx]), 32'(lane));
            chk({name, "_dt"},   32'(log_dt[idx]),   32'(dt));
        end else begin
            chk({name, "_present"}, 32'(log_lane.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int c0;
        logic [N*DW-1:0] d;
        logic [N-1:0]    v;

        rst_n     = 1'b0;
        hit_valid = '0;
        hit_dt    = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_sc_en",   32'(sc_en),    32'd0);
        chk("rst_sc_dt",   32'(sc_dt),    32'd0);
        chk("rst_sc_lane", 32'(sc_lane),  32'd0);
        chk("rst_pending", 32'(pending),  32'd0);
        chk("rst_drop",    32'(hit_drop), 32'd0);
        chk("rst_streak",  32'(streak),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single hit: two-cycle latency, exactly one issue
        c0 = cycle_no;
        cyc(5'b00001, put('0, 0, 5));
        idle(6);
        chk("t1_count", 32'(log_lane.size()), 32'd1);
        chk_log("t1", 0, 0, 5);
        if (log_cyc.size() > 0) chk("t1_latency", 32'(log_cyc[0] - c0), 32'd1);
        chk("t1_pending", 32'(pending), 32'd0);

        // simultaneous hits on lanes 0,2,4
        do_reset();
        d = put(put(put('0, 0, 10), 2, 20), 4, 30);
        cyc(5'b10101, d);
        idle(10);
        chk("t2_count", 32'(log_lane.size()), 32'd3);
        chk_log("t2a", 0, 0, 10);
        chk_log("t2b", 1, 2, 20);
        chk_log("t2c", 2, 4, 30);
        if (log_cyc.size() == 3) begin
            chk("t2_space1", 32'(log_cyc[1] - log_cyc[0]), 32'd3);
            chk("t2_space2", 32'(log_cyc[2] - log_cyc[1]), 32'd3);
        end

        // round robin after lane 2: lane 3 before lane 1
        do_reset();
        cyc(5'b00100, put('0, 2, 7));
        cyc(5'b01010, put(put('0, 1, 11), 3, 13));
        idle(10);
        chk("t3_count", 32'(log_lane.size()), 32'd3);
        chk_log("t3a", 0, 2, 7);
        chk_log("t3b", 1, 3, 13);
        chk_log("t3c", 2, 1, 11);

        // overflow drop while lane 1 waits through the gap
        do_reset();
        cyc(5'b00001, put('0, 0, 1));
        cyc(5'b00010, put('0, 1, 75));
        cyc(5'b00010, put('0, 1, 110));
        chk("t4_drop", 32'(hit_drop), 32'b00010);
        idle(8);
        chk("t4_count", 32'(log_lane.size()), 32'd2);
        chk_log("t4a", 0, 0, 1);
        chk_log("t4b", 1, 1, 75);

        // async reset mid-gap with lanes 0 and 3 held
        do_reset();
        cyc(5'b00010, put('0, 1, 9));
        cyc(5'b01001, put(put('0, 0, 3), 3, 4));
        chk("t5_pending_pre", 32'(pending), 32'b01001);
        chk("t5_en_pre", 32'(sc_en), 32'd1);
        @(negedge clk);
        hit_valid = '0;
        hit_dt    = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_sc_en",   32'(sc_en),    32'd0);
        chk("t5_sc_dt",   32'(sc_dt),    32'd0);
        chk("t5_sc_lane", 32'(sc_lane),  32'd0);
        chk("t5_pending", 32'(pending),  32'd0);
        chk("t5_drop",    32'(hit_drop), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        chk("t5_no_issue", 32'(log_lane.size()), 32'd0);

`ifdef SC_STREAK_EN
        do_reset();
        cyc(5'b00001, put('0, 0, 5));  idle(4);
        chk("s_1", 32'(streak), 32'd1);
        cyc(5'b00001, put('0, 0, 20)); idle(4);
        chk("s_2", 32'(streak), 32'd2);
        cyc(5'b00001, put('0, 0, 40)); idle(4);
        chk("s_3", 32'(streak), 32'd3);
        cyc(5'b00001, put('0, 0, 75)); idle(4);
        chk("s_0", 32'(streak), 32'd0);
        for (int i = 0; i < 256; i++) begin
            cyc(5'b00001, put('0, 0, 5));
            idle(3);
        end
        chk("s_sat", 32'(streak), 32'd255);
`endif

        // randomized traffic against the model
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            v = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 3) == 0);
                d = put(d, i, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 100))
                                                           : int'($urandom_range(0, 65535)));
            end
            cyc(v, d);
            if (t == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
